// File: rtl/string_match_pkg.sv
// Shared types and constants for the multi-pattern byte-stream matcher.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package string_match_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        LATCHED = 2'd2
    } fsm_state_t;

    localparam int DEF_NUM_PATTERNS = 4;
    localparam int DEF_MAX_LEN      = 17;
    localparam int DEF_CNT_W        = 16;

    // Window depth in bytes: whole words, deep enough that a MAX_LEN pattern
    // can end at the earliest byte of the newest word.
    function automatic int win_bytes(input int max_len);
        return 4 * ((max_len + 3 + 3) / 4);
    endfunction

endpackage

// File: rtl/multi_string_matcher_lane.sv
// One pattern slot: programmed string/length plus a 4-alignment compare.
// Latency: 1 cycle from window contents to registered hit.
// Backpressure: none; evaluates every cycle the window holds a fresh word.
module pattern_lane
    import string_match_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int WIN_B   = 20,
    parameter int LEN_W   = 5
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [LEN_W-1:0]     wr_len,
    input  logic [MAX_LEN*8-1:0] wr_string,
    input  logic                 win_valid,
    input  logic [WIN_B*8-1:0]   window,
    output logic                 en_next,
    output logic                 hit
);

    logic [LEN_W-1:0]     pat_len;
    logic [MAX_LEN*8-1:0] pat;
    logic [LEN_W-1:0]     wr_len_clamped;
    logic                 aln_ok;
    logic                 any_aln;
    byte_t                win_byte;

    // Lengths beyond MAX_LEN would index past the window, so they are clamped.
    assign wr_len_clamped = (wr_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : wr_len;

    // Enable state as it will be after this edge, so the FSM sees writes immediately.
    assign en_next = wr_en ? (wr_len_clamped != '0) : (pat_len != '0);

    // Slot registers: survive clear, only reset or a write changes them.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pat_len <= '0;
            pat     <= '0;
        end else if (wr_en) begin
            pat_len <= wr_len_clamped;
            pat     <= wr_string;
        end
    end

    // Alignment a ends the pattern at window byte a (byte 0 is the newest byte).
    always_comb begin
        any_aln  = 1'b0;
        aln_ok   = 1'b0;
        win_byte = '0;
        for (int a = 0; a < 4; a++) begin
            aln_ok = (pat_len != '0);
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < int'(pat_len)) begin
                    win_byte = window[8*(a + int'(pat_len) - 1 - i) +: 8];
                    if (win_byte != pat[8*i +: 8]) aln_ok = 1'b0;
                end
            end
            any_aln = any_aln | aln_ok;
        end
    end

    // Registered hit, qualified by a fresh word in the window; clear discards it.
    always_ff @(posedge clk) begin
        if (!n_rst || clear) hit <= 1'b0;
        else                 hit <= win_valid & any_aln;
    end

endmodule

// File: rtl/multi_string_matcher.sv
// Scans a 32-bit byte stream against NUM_PATTERNS programmable strings at all byte offsets.
// Latency: 2 cycles from accepted word to data_out/out_valid/match outputs.
// Backpressure: none; accepts one word per cycle, gaps with in_valid low are transparent.
module multi_string_matcher
    import string_match_pkg::*;
#(
    parameter  int NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter  int MAX_LEN      = DEF_MAX_LEN,
    parameter  int CNT_W        = DEF_CNT_W,
    localparam int IDX_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int LEN_W        = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [MAX_LEN*8-1:0]    cfg_string,
    input  logic                    sticky,
    input  logic                    in_valid,
    input  logic [31:0]             data_in,
    output logic                    out_valid,
    output logic [31:0]             data_out,
    output logic                    match,
    output logic [NUM_PATTERNS-1:0] match_vec,
    output logic [IDX_W-1:0]        match_idx,
    output logic [CNT_W-1:0]        match_count
);

    localparam int WIN_B = win_bytes(MAX_LEN);

    logic [WIN_B*8-1:0]      window;
    logic                    win_valid;
    logic [31:0]             data_d1;
    logic [NUM_PATTERNS-1:0] hit_vec;
    logic [NUM_PATTERNS-1:0] en_next;
    logic [NUM_PATTERNS-1:0] latched_vec;
    logic                    any_hit;
    fsm_state_t              state;
    fsm_state_t              state_next;

    assign any_hit = |hit_vec;

    // Byte window and first delay stage; shifts only on accepted words.
    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            window    <= '0;
            win_valid <= 1'b0;
            data_d1   <= '0;
        end else begin
            win_valid <= in_valid;
            if (in_valid) begin
                window  <= {window[WIN_B*8-33:0], data_in};
                data_d1 <= data_in;
            end
        end
    end

    // Second delay stage aligned with the registered lane hits; data holds between words.
    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= win_valid;
            if (win_valid) data_out <= data_d1;
        end
    end

    for (genvar p = 0; p < NUM_PATTERNS; p++) begin : g_lane
        pattern_lane #(
            .MAX_LEN (MAX_LEN),
            .WIN_B   (WIN_B),
            .LEN_W   (LEN_W)
        ) u_lane (
            .clk       (clk),
            .n_rst     (n_rst),
            .clear     (clear),
            .wr_en     (cfg_we && (cfg_idx == IDX_W'(p))),
            .wr_len    (cfg_len),
            .wr_string (cfg_string),
            .win_valid (win_valid),
            .window    (window),
            .en_next   (en_next[p]),
            .hit       (hit_vec[p])
        );
    end

    // Next-state logic: LATCHED is only left through clear or reset.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|en_next) state_next = SCAN;
            SCAN: begin
                if (sticky && any_hit) state_next = LATCHED;
                else if (!(|en_next))  state_next = IDLE;
            end
            LATCHED: state_next = LATCHED;
            default: state_next = IDLE;
        endcase
    end

    // State register; clear re-enters IDLE or SCAN depending on enabled slots.
    always_ff @(posedge clk) begin
        if (!n_rst)     state <= IDLE;
        else if (clear) state <= (|en_next) ? SCAN : IDLE;
        else            state <= state_next;
    end

    // Sticky hit accumulator, empty until the FSM latches.
    always_ff @(posedge clk) begin
        if (!n_rst || clear)           latched_vec <= '0;
        else if (state_next == LATCHED) latched_vec <= latched_vec | hit_vec;
    end

    // Output vector, OR and lowest-index priority encoder.
    always_comb begin
        match_vec = (state == LATCHED) ? (latched_vec | hit_vec) : hit_vec;
        match     = |match_vec;
        match_idx = '0;
        for (int p = NUM_PATTERNS - 1; p >= 0; p--) begin
            if (match_vec[p]) match_idx = IDX_W'(p);
        end
    end

    // Saturating count of output words carrying any fresh hit.
    always_ff @(posedge clk) begin
        if (!n_rst || clear)                                match_count <= '0;
        else if (out_valid && any_hit && (match_count != '1)) match_count <= match_count + 1'b1;
    end

endmodule

// File: doc/multi_string_matcher.md
# multi_string_matcher

Parametrised successor to the single-pattern MAC/payload string comparator. It scans a 32-bit byte stream against NUM_PATTERNS independently programmed byte strings, each up to MAX_LEN bytes, at every byte alignment. It reports per-pattern hits, a priority-encoded index, a saturating hit counter and a latency-matched copy of the data. It sits between the Ethernet receive word path and the flagging logic, and is programmed from the Atom over a simple write port.

## Interface
Parameters:
- NUM_PATTERNS, 4, number of pattern slots (1..16)
- MAX_LEN, 17, maximum pattern length in bytes (4..32)
- CNT_W, 16, width of match_count

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush of window, pipeline, FSM and counter; patterns are kept
- cfg_we  in  1  pattern write strobe
- cfg_idx  in  $clog2(NUM_PATTERNS)  slot written
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length in bytes; 0 disables the slot
- cfg_string  in  MAX_LEN×8  pattern; byte 0 in [7:0] is the first byte on the wire
- sticky  in  1  1 = hold hits until clear; 0 = per-word pulse
- in_valid  in  1  data_in carries a word
- data_in  in  32  [31:24] is the earliest byte, [7:0] the latest
- out_valid  out  1  in_valid delayed 2 cycles
- data_out  out  32  data_in delayed 2 cycles, same byte order
- match  out  1  OR of match_vec
- match_vec  out  NUM_PATTERNS  per-slot hit
- match_idx  out  $clog2(NUM_PATTERNS)  lowest set bit of match_vec; 0 when none
- match_count  out  CNT_W  saturating count of out_valid words with any fresh hit

## Operation
- Window: a byte shift register of W = 4·ceil((MAX_LEN+3)/4) bytes. It shifts 4 bytes only on in_valid, so gaps with in_valid low are transparent.
- Slot p hits on a word when its first len_p bytes equal the len_p window bytes ending at any of the 4 byte positions of that word, i.e. 4 alignments per word.
- A match may straddle up to ceil((MAX_LEN+3)/4) words.
- A slot with len 0 never hits. The comparison includes bytes of preceding words only if those bytes were accepted since the last reset or clear; flushed bytes are zero and compare normally.
- Config: a write updates slot registers at the edge. A word accepted in cycle t is compared against patterns written at or before cycle t.
- FSM: IDLE, SCAN, LATCHED.
  - IDLE: no slot enabled. Words pass through; match stays 0. Go to SCAN when any cfg_len != 0.
  - SCAN: pulse mode, or sticky mode with no hit yet. match_vec reflects the current output word only. On any hit with sticky=1, go to LATCHED.
  - LATCHED: match_vec ORs in new hits and never clears. Leave only via clear or reset, which go to IDLE or SCAN depending on enabled slots.
- Disabling all slots from SCAN goes to IDLE; in-flight results still emerge.
- match_count: +1 per out_valid cycle with any fresh hit, in either mode. It holds at all-ones.
- clear and in_valid in the same cycle: clear wins and the word is dropped. clear and cfg_we in the same cycle: the write is performed.
- Reset: all pattern lengths 0; all outputs 0; FSM in IDLE.

## Timing
- Cycle t: in_valid accepted. Edge t+1: window updated. Edge t+2: compare result registered with data_out and out_valid.
- Latency is a fixed 2 cycles. There is no backpressure; full throughput is 1 word per cycle.
- Between valid words, out_valid is 0 and data_out holds its last value. In pulse mode, match_vec is 0 on cycles with out_valid=0.
- clear at cycle t: all outputs except the pattern state are 0 after edge t+1; in-flight words are discarded.

## Structure
- Package string_match_pkg holds:
  - byte_t
  - fsm_state_t (IDLE, SCAN, LATCHED)
  - default parameter constants
  - a function for window depth W
- Sub-module pattern_lane: one slot's registers plus the 4-alignment compare with a registered hit output. It is instantiated NUM_PATTERNS times. The top level owns the window, the FSM, the priority encoder, the counter and the delay line.

## Test plan
- Slot 0 = "ABCD" (len 4); feed 0x41424344 → out_valid, match=1, match_vec=0001, match_idx=0 at exactly t+2; match_count=1.
- Slot 1 = 6-byte MAC 00:1A:2B:3C:4D:5E; feed 0xFF001A2B, 0x3C4D5EFF with a 3-cycle gap → hit on the second word only, match_idx=1.
- Slots 0 and 2 both hit the same word → match_vec=0101, match_idx=0. With sticky=1, the next non-matching words keep match_vec=0101 until clear pulses; after clear, all outputs are 0 and the FSM is in SCAN.
- Slot 3 = 17 bytes spanning 5 words at offset 3 → single hit on the final word; with a one-byte mismatch in the middle word → no hit.
- Pulse clear between the first and second half of a matching string → no hit; patterns survive and a full re-send hits.
- Force match_count to all-ones−1 with CNT_W=4, then feed 3 hits → count saturates at 0xF; n_rst low for one cycle → every output is 0 and the FSM is in IDLE.
